// File: rtl/clk_cl_hdr_pkg.sv
// rtl/clk_cl_hdr_pkg.sv - shared types and width helpers for the multi-cluster clock/reset header
package clk_cl_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECLK  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam int STATE_W = 2;

    function automatic int cnt_width(input int cken_pre, input int stagger);
        int m;
        m = (cken_pre > stagger) ? cken_pre : stagger;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(input int num_cl);
        return (num_cl > 1) ? $clog2(num_cl) : 1;
    endfunction

    // Scan chain: synchroniser flops, then state, counter, index and the three output vectors.
    function automatic int chain_len(input int num_cl, input int sync_stages,
                                     input int cken_pre, input int stagger);
        return (2 + num_cl) * sync_stages + STATE_W + cnt_width(cken_pre, stagger)
               + idx_width(num_cl) + 3 * num_cl;
    endfunction

endpackage

// File: rtl/clk_cl_sync.sv
// rtl/clk_cl_sync.sv - multi-flop input synchroniser with async clear and scan mux
module clk_cl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic se,
    input  logic si,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], se ? si : d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_cl_hdr_multi.sv
// rtl/clk_cl_hdr_multi.sv - multi-cluster clock-enable/reset header with staggered reset release
module clk_cl_hdr_multi
    import clk_cl_hdr_pkg::*;
#(
    parameter int NUM_CL      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CKEN_PRE    = 4,
    parameter int STAGGER     = 2
) (
    input  logic              gclk,
    input  logic              arst,
    input  logic              grst_l,
    input  logic              gdbginit_l,
    input  logic [NUM_CL-1:0] cluster_cken,
    input  logic              force_cken,
    input  logic              se,
    input  logic              si,
    output logic              so,
    output logic [NUM_CL-1:0] rclk_en,
    output logic [NUM_CL-1:0] cluster_grst_l,
    output logic [NUM_CL-1:0] dbginit_l,
    output logic              seq_busy
);

    localparam int CW     = cnt_width(CKEN_PRE, STAGGER);
    localparam int IW     = idx_width(NUM_CL);
    localparam int NSYNC  = 2 + NUM_CL;
    localparam int TAIL_W = STATE_W + CW + IW + 3 * NUM_CL;
    localparam int R_LSB  = STATE_W + CW + IW;

    logic [NSYNC-1:0] sync_d;
    logic [NSYNC-1:0] sync_q;
    logic [NSYNC:0]   sync_si;

    assign sync_d     = {cluster_cken, gdbginit_l, grst_l};
    assign sync_si[0] = si;

    for (genvar g = 0; g < NSYNC; g++) begin : g_sync
        clk_cl_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (gclk),
            .rst (arst),
            .se  (se),
            .si  (sync_si[g]),
            .d   (sync_d[g]),
            .q   (sync_q[g])
        );
        assign sync_si[g+1] = sync_q[g];
    end

    logic              grst_s;
    logic              dbg_s;
    logic [NUM_CL-1:0] cken_s;

    assign grst_s = sync_q[0];
    assign dbg_s  = sync_q[1];
    assign cken_s = sync_q[NSYNC-1:2];

    // All sequencing flops live in one vector so scan shifts through them in chain order.
    logic [TAIL_W-1:0] tail_q;
    logic [TAIL_W-1:0] tail_d;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CL-1:0] rclk_q, rclk_d, grst_q, grst_d, dbg_q, dbg_d;
    logic              abort;

    assign state_q = state_e'(tail_q[STATE_W-1:0]);
    assign cnt_q   = tail_q[STATE_W +: CW];
    assign idx_q   = tail_q[STATE_W+CW +: IW];
    assign rclk_q  = tail_q[R_LSB +: NUM_CL];
    assign grst_q  = tail_q[R_LSB+NUM_CL +: NUM_CL];
    assign dbg_q   = tail_q[R_LSB+2*NUM_CL +: NUM_CL];

    assign abort = (state_q != IDLE) && !grst_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rclk_d  = '1;
        grst_d  = grst_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            grst_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    grst_d = '0;
                    if (grst_s) begin
                        state_d = PRECLK;
                        cnt_d   = '0;
                    end
                end
                PRECLK: begin
                    if (cnt_q == CW'(CKEN_PRE - 1)) begin
                        grst_d[0] = 1'b1;
                        cnt_d     = '0;
                        idx_d     = IW'(1);
                        state_d   = (NUM_CL == 1) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CW'(STAGGER - 1)) begin
                        grst_d[idx_q] = 1'b1;
                        cnt_d         = '0;
                        idx_d         = idx_q + 1'b1;
                        if (idx_q == IW'(NUM_CL - 1)) begin
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    rclk_d = cken_s | {NUM_CL{force_cken}};
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // Debug-init follows the cluster's current reset, so it cannot lift before the cluster does.
        dbg_d  = abort ? '0 : ({NUM_CL{dbg_s}} & grst_q);
        tail_d = {dbg_d, grst_d, rclk_d, idx_d, cnt_d, state_d};
    end

    always_ff @(posedge gclk or posedge arst) begin
        if (arst) begin
            tail_q <= '0;
        end else if (se) begin
            tail_q <= {tail_q[TAIL_W-2:0], sync_si[NSYNC]};
        end else begin
            tail_q <= tail_d;
        end
    end

    assign so             = tail_q[TAIL_W-1];
    assign rclk_en        = rclk_q;
    assign cluster_grst_l = grst_q;
    assign dbginit_l      = dbg_q;
    assign seq_busy       = (state_q != RUN);

endmodule

// File: tb/tb_clk_cl_hdr_multi.sv
// tb/tb_clk_cl_hdr_multi.sv - randomized self-checking bench for clk_cl_hdr_multi
module tb_clk_cl_hdr_multi;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int P  = 4;
    localparam int G  = 2;
    localparam int CW = $clog2(P > G ? P : G);
    localparam int IW = $clog2(N);
    localparam int L  = (2 + N) * S + 2 + CW + IW + 3 * N;
    localparam int RB = (2 + N) * S + 2 + CW + IW;

    logic         gclk = 0;
    logic         arst, grst_l, gdbginit_l, force_cken, se, si;
    logic [N-1:0] cluster_cken;
    logic         so, seq_busy;
    logic [N-1:0] rclk_en, cluster_grst_l, dbginit_l;

    clk_cl_hdr_multi #(.NUM_CL(N), .SYNC_STAGES(S), .CKEN_PRE(P), .STAGGER(G)) dut (
        .gclk           (gclk),
        .arst           (arst),
        .grst_l         (grst_l),
        .gdbginit_l     (gdbginit_l),
        .cluster_cken   (cluster_cken),
        .force_cken     (force_cken),
        .se             (se),
        .si             (si),
        .so             (so),
        .rclk_en        (rclk_en),
        .cluster_grst_l (cluster_grst_l),
        .dbginit_l      (dbginit_l),
        .seq_busy       (seq_busy)
    );

    always #5 gclk = ~gclk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: delay lines for the synchronisers, and the sequence expressed as
    // edges elapsed since sequencing began.
    logic         q_g[$], q_d[$];
    logic [N-1:0] q_c[$];
    logic [N-1:0] m_rclk, m_cl, m_dbg;
    bit           m_active;
    int           m_s;

    function automatic int rel_count(input int s);
        int r;
        if (s < P) return 0;
        r = 1 + (s - P) / G;
        return (r > N) ? N : r;
    endfunction

    function automatic logic [N-1:0] rel_mask(input int s);
        logic [N-1:0] m = '0;
        for (int i = 0; i < rel_count(s); i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic bit m_run();
        return m_active && (rel_count(m_s) == N);
    endfunction

    always @(posedge gclk or posedge arst) begin
        if (arst) begin
            q_g.delete(); q_d.delete(); q_c.delete();
            for (int i = 0; i < S; i++) begin
                q_g.push_back(1'b0); q_d.push_back(1'b0); q_c.push_back('0);
            end
            m_rclk = '0; m_cl = '0; m_dbg = '0; m_active = 0; m_s = 0;
        end else if (!se) begin
            logic g, d;
            logic [N-1:0] c, old_cl;
            bit run_pre;
            g = q_g[S-1]; d = q_d[S-1]; c = q_c[S-1];
            old_cl  = m_cl;
            run_pre = m_run();
            if (!m_active) begin
                m_rclk = '1; m_cl = '0; m_dbg = {N{d}} & old_cl;
                if (g) begin m_active = 1; m_s = 0; end
            end else if (!g) begin
                m_active = 0; m_s = 0; m_cl = '0; m_dbg = '0; m_rclk = '1;
            end else begin
                m_dbg = {N{d}} & old_cl;
                if (run_pre) begin
                    m_rclk = c | {N{force_cken}};
                end else begin
                    m_rclk = '1;
                    m_s++;
                    m_cl = rel_mask(m_s);
                end
            end
            q_g.push_front(grst_l); void'(q_g.pop_back());
            q_d.push_front(gdbginit_l); void'(q_d.pop_back());
            q_c.push_front(cluster_cken); void'(q_c.pop_back());
        end
    end

    always @(negedge gclk) begin
        if (chk_en && !arst) begin
            chk("rclk_en", 32'(rclk_en), 32'(m_rclk));
            chk("cluster_grst_l", 32'(cluster_grst_l), 32'(m_cl));
            chk("dbginit_l", 32'(dbginit_l), 32'(m_dbg));
            chk("seq_busy", 32'(seq_busy), 32'(!m_run()));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge gclk);
    endtask

    logic         pat [0:2*L-1];
    logic [N-1:0] e_r, e_c, e_d;

    initial begin
        arst = 1; grst_l = 1; gdbginit_l = 1; cluster_cken = '1;
        force_cken = 0; se = 0; si = 0;
        edges(3);
        chk("rst_rclk_en", 32'(rclk_en), 32'h0);
        chk("rst_grst", 32'(cluster_grst_l), 32'h0);
        chk("rst_dbg", 32'(dbginit_l), 32'h0);
        chk("rst_busy", 32'(seq_busy), 32'h1);
        chk("rst_so", 32'(so), 32'h0);
        arst = 0; chk_en = 1;

        // Staggered release, then abort right after cluster 1 leaves reset.
        edges(7);
        chk("rel_edge6", 32'(cluster_grst_l), 32'h1);
        edges(2);
        chk("rel_edge8", 32'(cluster_grst_l), 32'h3);
        grst_l = 0;
        edges(3);
        chk("abort_grst", 32'(cluster_grst_l), 32'h0);
        chk("abort_rclk", 32'(rclk_en), 32'hf);
        chk("abort_busy", 32'(seq_busy), 32'h1);
        grst_l = 1;
        edges(16);
        chk("restart_grst", 32'(cluster_grst_l), 32'hf);
        chk("restart_busy", 32'(seq_busy), 32'h0);

        cluster_cken = 4'b0101;
        edges(3);
        chk("gate_0101", 32'(rclk_en), 32'h5);
        force_cken = 1;
        edges(1);
        chk("gate_force", 32'(rclk_en), 32'hf);
        force_cken = 0;
        edges(1);

        gdbginit_l = 0;
        edges(3);
        chk("dbg_low", 32'(dbginit_l), 32'h0);
        grst_l = 0;
        edges(4);
        gdbginit_l = 1;
        edges(4);
        chk("dbg_in_rst", 32'(dbginit_l), 32'h0);
        grst_l = 1;
        edges(5);
        chk("dbg_preclk", 32'(dbginit_l), 32'h0);
        edges(20);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cluster_cken = N'($urandom);
            if ($urandom_range(0, 15) == 0) force_cken = ~force_cken;
            if ($urandom_range(0, 31) == 0) gdbginit_l = ~gdbginit_l;
            if (grst_l && $urandom_range(0, 79) == 0) grst_l = 0;
            else if (!grst_l && $urandom_range(0, 3) == 0) grst_l = 1;
            edges(1);
        end

        gdbginit_l = 1; grst_l = 1; force_cken = 0;
        edges(20);
        #2 arst = 1;
        #1;
        chk("arst_rclk", 32'(rclk_en), 32'h0);
        chk("arst_grst", 32'(cluster_grst_l), 32'h0);
        chk("arst_dbg", 32'(dbginit_l), 32'h0);
        chk("arst_busy", 32'(seq_busy), 32'h1);
        edges(1);
        arst = 0;
        edges(20);
        chk("arst_restart", 32'(cluster_grst_l), 32'hf);

        chk_en = 0; se = 1;
        for (int e = 0; e < 2 * L; e++) pat[e] = 1'($urandom_range(0, 1));
        for (int e = 0; e < 2 * L; e++) begin
            si = pat[e];
            edges(1);
            if (e >= L - 1) chk("scan_so", 32'(so), 32'(pat[e-L+1]));
        end
        for (int i = 0; i < N; i++) begin
            e_r[i] = pat[2*L-1-(RB+i)];
            e_c[i] = pat[2*L-1-(RB+N+i)];
            e_d[i] = pat[2*L-1-(RB+2*N+i)];
        end
        chk("scan_rclk", 32'(rclk_en), 32'(e_r));
        chk("scan_grst", 32'(cluster_grst_l), 32'(e_c));
        chk("scan_dbg", 32'(dbginit_l), 32'(e_d));
        se = 0; arst = 1;
        edges(1);
        arst = 0;
        edges(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
